lcd_controller: RTL and testbench
=================================

// Module: lcd_controller
// PURPOSE
//  Sequencer for the DE2 HD44780 character LCD pins (lcd_data/rw/en/rs/on/blon).
//  Runs the power-up init sequence, then accepts one command/character byte at a time
//  from game logic via valid/ready, generating EN pulses and post-byte delays.
//  Write-only: lcd_rw tied low, busy flag never read; timing is delay-based.
// PARAMETERS
//  POWERUP_CYCLES    750000  idle clocks after reset before first init byte (15 ms @ 50 MHz)
//  SETUP_CYCLES      2       clocks with RS/DATA stable before EN rises (>=40 ns)
//  EN_HIGH_CYCLES    12      EN high width in clocks (>=230 ns)
//  HOLD_CYCLES       2       clocks RS/DATA held after EN falls
//  CMD_WAIT_CYCLES   2500    post-byte wait, normal commands/data (50 us)
//  CLEAR_WAIT_CYCLES 82000   post-byte wait for clear (0x01) / home (0x02, 0x03) with RS=0
// PORTS
//  clock      in  1  system clock
//  reset      in  1  synchronous, active-high
//  req_valid  in  1  request byte available
//  req_rs     in  1  0 = instruction, 1 = character data
//  req_data   in  8  byte to write
//  req_ready  out 1  controller can accept a byte this cycle
//  init_done  out 1  init sequence complete; sticky until reset
//  lcd_data   out 8  LCD DB7..DB0
//  lcd_rw     out 1  constant 0
//  lcd_en     out 1  LCD enable strobe
//  lcd_rs     out 1  LCD register select
//  lcd_on     out 1  constant 1
//  lcd_blon   out 1  constant 1
// BEHAVIOUR
//  Reset values (output on the cycle after reset is sampled high):
//   lcd_data=0, lcd_en=0, lcd_rs=0, req_ready=0, init_done=0, state=POWERUP, counter=0.
//  Outputs are registered: lcd_en/lcd_rs/lcd_data change only on clock edges.
//  Init ROM, all RS=0, in order: 0x38 (8-bit, 2-line), 0x0C (display on, cursor off),
//   0x01 (clear), 0x06 (entry mode, increment). Index 2 uses CLEAR_WAIT_CYCLES.
//  FSM states:
//   POWERUP  count POWERUP_CYCLES -> LOAD with init index 0.
//   LOAD     drive lcd_rs/lcd_data from the init ROM entry or from the latched request -> SETUP.
//   SETUP    SETUP_CYCLES -> EN_HIGH.
//   EN_HIGH  lcd_en=1 for exactly EN_HIGH_CYCLES -> HOLD.
//   HOLD     lcd_en=0, data held HOLD_CYCLES -> WAIT.
//   WAIT     CMD_WAIT_CYCLES, or CLEAR_WAIT_CYCLES if long cmd. During init: the next index
//            goes to LOAD. After the last init entry: set init_done, go to IDLE.
//            After a user byte: go to IDLE.
//   IDLE     req_ready=1. Accept when req_valid&&req_ready; latch req_rs/req_data -> LOAD.
//  req_ready is high only in IDLE (registered as state==IDLE), so at most one byte is accepted
//   per transaction. req_valid while not ready is ignored, and the requester holds it.
//  Long cmd = (rs==0) && (data==0x01 || data[7:1]==7'b0000001).
//  Accept-to-EN-rise latency: 1 (LOAD) + SETUP_CYCLES clocks.
//  lcd_data/lcd_rs keep the last byte in IDLE. No glitch on lcd_en between bytes.
//  Delay counter width: $clog2(max of all cycle params)+1. Counter clears on every
//   state change and counts 0..N-1.
//  Reset mid-transaction: lcd_en low on the next edge and init restarts from POWERUP.
//  The latched byte is discarded.
// STRUCTURE
//  lcd_pkg: state enum; init ROM constants (LCD_FUNC_SET=8'h38, LCD_DISP_ON=8'h0C,
//   LCD_CLEAR=8'h01, LCD_ENTRY=8'h06); INIT_LEN=4; is_long_cmd() function.
//  Sub-module lcd_delay_counter: load value plus done pulse, shared by all timed states.
// TESTING (bench params: POWERUP=20, SETUP=2, EN_HIGH=4, HOLD=2, CMD_WAIT=10, CLEAR_WAIT=50)
//  Reset released -> lcd_en low for 20 cycles, then 4 EN pulses of 4 cycles each with data
//   38,0C,01,06 and rs=0; >=50 cycles after pulse 3; init_done and req_ready rise together.
//  IDLE, valid rs=1 data=0x41 for 1 cycle -> ready falls next cycle; EN rises 3 cycles after
//   accept with data=0x41, rs=1; ready returns after 2+4+2+10 further cycles.
//  Request rs=0 data=0x02 -> 50-cycle wait; rs=1 data=0x01 -> 10-cycle wait (data, not clear).
//  req_valid held high with changing data during a transaction -> only the byte present at
//   the accepting edge is written; the next byte is accepted on the next IDLE cycle.
//  Reset asserted while lcd_en=1 -> lcd_en=0 next cycle, init_done=0, full init replays.
//  Checker throughout: lcd_rw==0, lcd_on==1, lcd_blon==1, and lcd_data/lcd_rs stable
//   whenever lcd_en==1.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 character LCD sequencer.
// Holds the state encoding, the init ROM bytes and the long-command predicate.
package lcd_pkg;

    localparam int unsigned INIT_LEN   = 4;
    localparam int unsigned INIT_IDX_W = 2;

    localparam logic [7:0] LCD_FUNC_SET = 8'h38;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;

    typedef enum logic [2:0] {
        ST_POWERUP,
        ST_LOAD,
        ST_SETUP,
        ST_EN_HIGH,
        ST_HOLD,
        ST_WAIT,
        ST_IDLE
    } lcd_state_e;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } lcd_byte_t;

    function automatic logic [7:0] init_rom(input logic [INIT_IDX_W-1:0] idx);
        case (idx)
            2'd0:    return LCD_FUNC_SET;
            2'd1:    return LCD_DISP_ON;
            2'd2:    return LCD_CLEAR;
            default: return LCD_ENTRY;
        endcase
    endfunction

    // Clear and return-home instructions need the long post-byte wait.
    function automatic logic is_long_cmd(input lcd_byte_t b);
        return !b.rs && ((b.data == LCD_CLEAR) || (b.data[7:1] == 7'b0000001));
    endfunction

endpackage

// File: rtl/lcd_if.sv
// Byte request channel from game logic into the LCD sequencer (valid/ready).
interface lcd_if;

    logic       req_valid;
    logic       req_rs;
    logic [7:0] req_data;
    logic       req_ready;

    modport master (
        output req_valid,
        output req_rs,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_rs,
        input  req_data,
        output req_ready
    );

endinterface

// File: rtl/lcd_delay_counter.sv
// Delay counter shared by all timed states: cleared on load, flags the last
// cycle of a len_i-cycle interval.
module lcd_delay_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] len_i,
    output logic             done_c
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = load_i ? '0 : count_q + CNT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_c = (count_q == (len_i - CNT_W'(1)));

endmodule

// File: rtl/lcd_controller.sv
// HD44780 write-only sequencer: power-up init ROM, then one byte per
// valid/ready handshake, with EN strobe timing and post-byte delays.
module lcd_controller
    import lcd_pkg::*;
#(
    parameter int unsigned POWERUP_CYCLES    = 750000,
    parameter int unsigned SETUP_CYCLES      = 2,
    parameter int unsigned EN_HIGH_CYCLES    = 12,
    parameter int unsigned HOLD_CYCLES       = 2,
    parameter int unsigned CMD_WAIT_CYCLES   = 2500,
    parameter int unsigned CLEAR_WAIT_CYCLES = 82000
) (
    input  logic       clock,
    input  logic       reset,
    lcd_if.slave       req,
    output logic       init_done,
    output logic [7:0] lcd_data,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic       lcd_rs,
    output logic       lcd_on,
    output logic       lcd_blon
);

    localparam int unsigned MAX_A = (POWERUP_CYCLES > CLEAR_WAIT_CYCLES) ?
                                    POWERUP_CYCLES : CLEAR_WAIT_CYCLES;
    localparam int unsigned MAX_B = (CMD_WAIT_CYCLES > EN_HIGH_CYCLES) ?
                                    CMD_WAIT_CYCLES : EN_HIGH_CYCLES;
    localparam int unsigned MAX_C = (SETUP_CYCLES > HOLD_CYCLES) ?
                                    SETUP_CYCLES : HOLD_CYCLES;
    localparam int unsigned MAX_AB = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned MAX_CYCLES = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
    localparam int unsigned CNT_W = $clog2(MAX_CYCLES) + 1;

    lcd_state_e              state_q, state_d;
    logic [INIT_IDX_W-1:0]   idx_q, idx_d;
    logic                    init_done_q, init_done_d;
    lcd_byte_t               req_byte_q, req_byte_d;
    lcd_byte_t               out_q, out_d;
    logic                    lcd_en_q;
    logic                    req_ready_q;

    logic                    load_c;
    logic                    done_c;
    logic [CNT_W-1:0]        delay_len_c;

    lcd_delay_counter #(
        .CNT_W (CNT_W)
    ) u_delay (
        .clock  (clock),
        .reset  (reset),
        .load_i (load_c),
        .len_i  (delay_len_c),
        .done_c (done_c)
    );

    // Next-state, interval length and datapath selection.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        init_done_d = init_done_q;
        req_byte_d  = req_byte_q;
        out_d       = out_q;
        delay_len_c = CNT_W'(CMD_WAIT_CYCLES);

        case (state_q)
            ST_POWERUP: begin
                delay_len_c = CNT_W'(POWERUP_CYCLES);
                if (done_c) begin
                    idx_d   = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (init_done_q) begin
                    out_d = req_byte_q;
                end else begin
                    out_d.rs   = 1'b0;
                    out_d.data = init_rom(idx_q);
                end
                state_d = ST_SETUP;
            end
            ST_SETUP: begin
                delay_len_c = CNT_W'(SETUP_CYCLES);
                if (done_c) state_d = ST_EN_HIGH;
            end
            ST_EN_HIGH: begin
                delay_len_c = CNT_W'(EN_HIGH_CYCLES);
                if (done_c) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                delay_len_c = CNT_W'(HOLD_CYCLES);
                if (done_c) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // out_q still holds the byte just written, so it picks the wait.
                delay_len_c = is_long_cmd(out_q) ? CNT_W'(CLEAR_WAIT_CYCLES)
                                                 : CNT_W'(CMD_WAIT_CYCLES);
                if (done_c) begin
                    if (init_done_q) begin
                        state_d = ST_IDLE;
                    end else if (idx_q == INIT_IDX_W'(INIT_LEN - 1)) begin
                        init_done_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + INIT_IDX_W'(1);
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_IDLE: begin
                if (req.req_valid && req_ready_q) begin
                    req_byte_d.rs   = req.req_rs;
                    req_byte_d.data = req.req_data;
                    state_d         = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_POWERUP;
            end
        endcase

        load_c = (state_d != state_q);
    end

    // State and registered pin outputs; EN and ready follow the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_POWERUP;
            idx_q       <= '0;
            init_done_q <= 1'b0;
            req_byte_q  <= '0;
            out_q       <= '0;
            lcd_en_q    <= 1'b0;
            req_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            init_done_q <= init_done_d;
            req_byte_q  <= req_byte_d;
            out_q       <= out_d;
            lcd_en_q    <= (state_d == ST_EN_HIGH);
            req_ready_q <= (state_d == ST_IDLE);
        end
    end

    assign req.req_ready = req_ready_q;
    assign init_done     = init_done_q;
    assign lcd_data      = out_q.data;
    assign lcd_rs        = out_q.rs;
    assign lcd_en        = lcd_en_q;
    assign lcd_rw        = 1'b0;
    assign lcd_on        = 1'b1;
    assign lcd_blon      = 1'b1;

endmodule

// File: tb/tb_lcd_controller.sv
// Scoreboard bench for lcd_controller: stimulus pushes expected EN pulses,
// a monitor pops and checks each pulse's byte, width and following gap.
module tb_lcd_controller;

    localparam int unsigned P_POWERUP = 20;
    localparam int unsigned P_SETUP   = 2;
    localparam int unsigned P_EN_HIGH = 4;
    localparam int unsigned P_HOLD    = 2;
    localparam int unsigned P_CMD     = 10;
    localparam int unsigned P_CLEAR   = 50;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         gap;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       init_done;
    logic [7:0] lcd_data;
    logic       lcd_rw, lcd_en, lcd_rs, lcd_on, lcd_blon;

    lcd_if req_if ();

    lcd_controller #(
        .POWERUP_CYCLES    (P_POWERUP),
        .SETUP_CYCLES      (P_SETUP),
        .EN_HIGH_CYCLES    (P_EN_HIGH),
        .HOLD_CYCLES       (P_HOLD),
        .CMD_WAIT_CYCLES   (P_CMD),
        .CLEAR_WAIT_CYCLES (P_CLEAR)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req_if),
        .init_done (init_done),
        .lcd_data  (lcd_data),
        .lcd_rw    (lcd_rw),
        .lcd_en    (lcd_en),
        .lcd_rs    (lcd_rs),
        .lcd_on    (lcd_on),
        .lcd_blon  (lcd_blon)
    );

    always #5 clock = ~clock;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic abort_mon = 1'b1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every EN rise pops one expected byte; width and low gap are timed.
    initial begin : monitor
        logic       en_prev, rdy_prev, in_gap, lat_rs;
        logic [7:0] lat_data;
        int         hi, lo;
        exp_t       cur;
        en_prev = 1'b0; rdy_prev = 1'b0; in_gap = 1'b0;
        lat_rs = 1'b0; lat_data = 8'h00; hi = 0; lo = 0;
        cur = '{rs: 1'b0, data: 8'h00, gap: -1};
        forever begin
            @(negedge clock);
            if (abort_mon) begin
                in_gap = 1'b0;
                hi     = 0;
            end else begin
                check("const_pins", int'({lcd_rw, lcd_on, lcd_blon}), 3);
                if (lcd_en && en_prev) begin
                    check("stable_rs", int'(lcd_rs), int'(lat_rs));
                    check("stable_data", int'(lcd_data), int'(lat_data));
                end
                if (in_gap) begin
                    lo++;
                    if ((lcd_en && !en_prev) || (req_if.req_ready && !rdy_prev)) begin
                        check("post_byte_gap", lo, cur.gap);
                        in_gap = 1'b0;
                    end
                end
                if (lcd_en && !en_prev) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_en: got EN pulse data 0x%0h, expected none", lcd_data);
                        cur.gap = -1;
                    end else begin
                        cur = exp_q.pop_front();
                        check("pulse_rs", int'(lcd_rs), int'(cur.rs));
                        check("pulse_data", int'(lcd_data), int'(cur.data));
                    end
                    lat_rs   = lcd_rs;
                    lat_data = lcd_data;
                    hi       = 1;
                end else if (lcd_en) begin
                    hi++;
                end else if (en_prev) begin
                    check("en_width", hi, int'(P_EN_HIGH));
                    in_gap = 1'b1;
                    lo     = 0;
                end
            end
            en_prev  = lcd_en;
            rdy_prev = req_if.req_ready;
        end
    end

    task automatic push(input logic rs, input logic [7:0] data, input int gap);
        exp_t e;
        e.rs = rs; e.data = data; e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic wait_ready(input int budget);
        int n;
        n = 0;
        while (!req_if.req_ready && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (!req_if.req_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got ready=0 after %0d cycles, expected 1", n);
        end
    endtask

    // Release reset (called on a negedge) and check the whole init replay.
    task automatic run_init();
        int   n;
        logic done_before;
        exp_q.delete();
        push(1'b0, 8'h38, 15);
        push(1'b0, 8'h0C, 15);
        push(1'b0, 8'h01, 55);
        push(1'b0, 8'h06, 12);
        reset = 1'b0;
        @(negedge clock);
        abort_mon = 1'b0;
        n = 1;
        while (!lcd_en && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("reset_to_first_en", n, 23);
        done_before = 1'b0;
        n = 0;
        while (!req_if.req_ready && n < 400) begin
            done_before = init_done;
            @(negedge clock);
            n++;
        end
        check("init_ready", int'(req_if.req_ready), 1);
        check("init_done_with_ready", int'(init_done), 1);
        check("init_done_not_early", int'(done_before), 0);
    endtask

    // One handshake byte; checks ready drop and accept-to-EN latency.
    task automatic send(input logic rs, input logic [7:0] data, input int gap);
        int n;
        wait_ready(200);
        req_if.req_valid = 1'b1;
        req_if.req_rs    = rs;
        req_if.req_data  = data;
        push(rs, data, gap);
        @(negedge clock);
        req_if.req_valid = 1'b0;
        req_if.req_data  = 8'hEE;
        check("ready_fall", int'(req_if.req_ready), 0);
        n = 1;
        while (!lcd_en && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("accept_to_en", n, 4);
        wait_ready(200);
    endtask

    initial begin : stimulus
        logic       bb_rs[3];
        logic [7:0] bb_data[3];
        int         bb_gap[3];
        int         k, cyc;

        req_if.req_valid = 1'b0;
        req_if.req_rs    = 1'b0;
        req_if.req_data  = 8'h00;
        repeat (3) @(negedge clock);
        check("rst_en", int'(lcd_en), 0);
        check("rst_ready", int'(req_if.req_ready), 0);
        check("rst_init_done", int'(init_done), 0);
        check("rst_data", int'(lcd_data), 0);
        check("rst_rs", int'(lcd_rs), 0);

        run_init();

        send(1'b1, 8'h41, 12);
        send(1'b0, 8'h02, 52);
        send(1'b1, 8'h01, 12);
        send(1'b0, 8'h03, 52);
        send(1'b0, 8'hC0, 12);
        send(1'b0, 8'h01, 52);

        // Valid held high with churning data: only bytes at accepting edges count.
        bb_rs[0] = 1'b1; bb_data[0] = 8'h42; bb_gap[0] = 12;
        bb_rs[1] = 1'b0; bb_data[1] = 8'h01; bb_gap[1] = 52;
        bb_rs[2] = 1'b1; bb_data[2] = 8'h43; bb_gap[2] = 12;
        wait_ready(200);
        req_if.req_valid = 1'b1;
        k = 0;
        cyc = 0;
        while (k < 3 && cyc < 1000) begin
            if (req_if.req_ready) begin
                req_if.req_rs   = bb_rs[k];
                req_if.req_data = bb_data[k];
                push(bb_rs[k], bb_data[k], bb_gap[k]);
                k++;
            end else begin
                req_if.req_rs   = 1'($urandom);
                req_if.req_data = 8'($urandom);
            end
            @(negedge clock);
            cyc++;
        end
        req_if.req_valid = 1'b0;
        check("held_valid_accepts", k, 3);
        wait_ready(200);

        // Reset in the middle of an EN pulse.
        req_if.req_valid = 1'b1;
        req_if.req_rs    = 1'b1;
        req_if.req_data  = 8'h55;
        push(1'b1, 8'h55, 12);
        @(negedge clock);
        req_if.req_valid = 1'b0;
        cyc = 0;
        while (!lcd_en && cyc < 50) begin
            @(negedge clock);
            cyc++;
        end
        check("pre_reset_en", int'(lcd_en), 1);
        @(negedge clock);
        abort_mon = 1'b1;
        reset     = 1'b1;
        @(negedge clock);
        check("midreset_en", int'(lcd_en), 0);
        check("midreset_init_done", int'(init_done), 0);
        check("midreset_ready", int'(req_if.req_ready), 0);
        run_init();

        send(1'b1, 8'h5A, 12);
        repeat (5) @(negedge clock);
        check("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
